// File: rtl/tcas_pkg.sv
// Shared constants and FSM state type for the TCAS track scheduler.
// Used by tcas_track_table and tcas_track_scheduler.
package tcas_pkg;

  localparam logic [1:0] OM_RESET = 2'b00;
  localparam logic [1:0] OM_TA    = 2'b01;
  localparam logic [1:0] OM_TARA  = 2'b10;

  localparam logic [2:0] TRAFFIC_RESET    = 3'b000;
  localparam logic [2:0] TRAFFIC_NONE     = 3'b001;
  localparam logic [2:0] TRAFFIC_ADVISORY = 3'b010;

  localparam logic [2:0] RA_RESET   = 3'b000;
  localparam logic [2:0] RA_NONE    = 3'b001;
  localparam logic [2:0] RA_DESCEND = 3'b010;
  localparam logic [2:0] RA_CLIMB   = 3'b011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AGE,
    ST_SELECT,
    ST_ISSUE,
    ST_DONE
  } state_e;

  // Mode 11 is treated like reset mode.
  function automatic logic om_active(input logic [1:0] om);
    return (om == OM_TA) || (om == OM_TARA);
  endfunction

endpackage

// File: rtl/tcas_track_table.sv
// Per-slot valid/age store for intruder tracks; ages on age_step, refreshes on upd.
// A refresh in the same cycle as an age step on the same slot takes precedence.
module tcas_track_table
  import tcas_pkg::*;
#(
  parameter int N_TRK   = 4,
  parameter int IDW     = 2,
  parameter int AGE_MAX = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             upd_valid_i,
  input  logic [IDW-1:0]   upd_id_i,
  input  logic             age_step_i,
  output logic [N_TRK-1:0] valid_o
);

  localparam int AW = $clog2(AGE_MAX + 1);

  logic [N_TRK-1:0] valid_q, valid_d;
  logic [AW-1:0]    age_q [N_TRK];
  logic [AW-1:0]    age_d [N_TRK];

  always_comb begin
    for (int i = 0; i < N_TRK; i++) begin
      valid_d[i] = valid_q[i];
      age_d[i]   = age_q[i];
      if (age_step_i && valid_q[i]) begin
        if (age_q[i] == AW'(AGE_MAX - 1)) begin
          valid_d[i] = 1'b0;
          age_d[i]   = '0;
        end else begin
          age_d[i] = age_q[i] + 1'b1;
        end
      end
      if (upd_valid_i && (upd_id_i == IDW'(i))) begin
        valid_d[i] = 1'b1;
        age_d[i]   = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < N_TRK; i++) age_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < N_TRK; i++) age_q[i] <= age_d[i];
    end
  end

  assign valid_o = valid_q;

endmodule

// File: rtl/tcas_track_scheduler.sv
// Round-robin TCAS threat scheduler over N_TRK track slots sharing one evaluation datapath.
// Optional TCAS_STATS_EN adds saturating round/overrun counters.
module tcas_track_scheduler
  import tcas_pkg::*;
#(
  parameter int N_TRK   = 4,
  parameter int IDW     = 2,
  parameter int AGE_MAX = 15,
  parameter int EVAL_TO = 63
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     om,
  input  logic           upd_valid,
  input  logic [IDW-1:0] upd_id,
  input  logic           scan_tick,
  output logic           eval_req,
  output logic [IDW-1:0] eval_id,
  output logic           eval_ra_en,
  input  logic           eval_ack,
  input  logic           eval_ta,
  input  logic           eval_ra,
  input  logic [2:0]     eval_man,
  output logic [2:0]     tcas_traffic,
  output logic [2:0]     tcas_resolution,
  output logic [IDW-1:0] threat_id,
  output logic           busy,
  output logic           eval_err
`ifdef TCAS_STATS_EN
  ,
  output logic [15:0]    round_cnt,
  output logic [15:0]    overrun_cnt
`endif
);

  localparam int TW = $clog2(EVAL_TO + 1);

  state_e           state_q;
  logic [IDW-1:0]   ptr_q;
  logic [TW-1:0]    tmr_q;
  logic             req_q, busy_q, err_q;
  logic             ta_any_q, ra_any_q;
  logic [IDW-1:0]   ta_id_q, ra_id_q, tid_q;
  logic [2:0]       man_q, traffic_q, res_q;
  logic [N_TRK-1:0] trk_valid;
  logic             om_on, ra_mode;

  assign om_on   = om_active(om);
  assign ra_mode = (om == OM_TARA);

  tcas_track_table #(
    .N_TRK  (N_TRK),
    .IDW    (IDW),
    .AGE_MAX(AGE_MAX)
  ) u_table (
    .clk        (clk),
    .rst        (rst),
    .upd_valid_i(upd_valid),
    .upd_id_i   (upd_id),
    .age_step_i (state_q == ST_AGE),
    .valid_o    (trk_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      tmr_q     <= '0;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      ta_any_q  <= 1'b0;
      ra_any_q  <= 1'b0;
      ta_id_q   <= '0;
      ra_id_q   <= '0;
      man_q     <= '0;
      traffic_q <= TRAFFIC_RESET;
      res_q     <= RA_RESET;
      tid_q     <= '0;
    end else if (!om_on) begin
      // Leaving an operating mode aborts the round; the track table is kept.
      state_q   <= ST_IDLE;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      traffic_q <= TRAFFIC_RESET;
      res_q     <= RA_RESET;
      tid_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (scan_tick) begin
            state_q <= ST_AGE;
            busy_q  <= 1'b1;
          end
        end
        ST_AGE: begin
          ptr_q    <= '0;
          ta_any_q <= 1'b0;
          ra_any_q <= 1'b0;
          ta_id_q  <= '0;
          ra_id_q  <= '0;
          man_q    <= '0;
          state_q  <= ST_SELECT;
        end
        ST_SELECT: begin
          if (trk_valid[ptr_q]) begin
            state_q <= ST_ISSUE;
            req_q   <= 1'b1;
            tmr_q   <= '0;
          end else if (ptr_q == IDW'(N_TRK - 1)) begin
            state_q <= ST_DONE;
          end else begin
            ptr_q <= ptr_q + 1'b1;
          end
        end
        ST_ISSUE: begin
          // A timed-out evaluation commits as ta=0/ra=0.
          if (eval_ack || (tmr_q == TW'(EVAL_TO - 1))) begin
            req_q <= 1'b0;
            if (!eval_ack) err_q <= 1'b1;
            if (eval_ack && eval_ta && !ta_any_q) begin
              ta_any_q <= 1'b1;
              ta_id_q  <= ptr_q;
            end
            if (eval_ack && eval_ra && ra_mode && !ra_any_q) begin
              ra_any_q <= 1'b1;
              ra_id_q  <= ptr_q;
              man_q    <= eval_man;
            end
            if (ptr_q == IDW'(N_TRK - 1)) begin
              state_q <= ST_DONE;
            end else begin
              ptr_q   <= ptr_q + 1'b1;
              state_q <= ST_SELECT;
            end
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        ST_DONE: begin
          traffic_q <= (ta_any_q || ra_any_q) ? TRAFFIC_ADVISORY : TRAFFIC_NONE;
          res_q     <= (ra_mode && ra_any_q) ? man_q : RA_NONE;
          tid_q     <= ra_any_q ? ra_id_q : (ta_any_q ? ta_id_q : '0);
          busy_q    <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef TCAS_STATS_EN
  logic [15:0] round_cnt_q, overrun_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      round_cnt_q   <= '0;
      overrun_cnt_q <= '0;
    end else begin
      if (om_on && (state_q == ST_DONE) && !(&round_cnt_q))
        round_cnt_q <= round_cnt_q + 1'b1;
      if (scan_tick && busy_q && !(&overrun_cnt_q))
        overrun_cnt_q <= overrun_cnt_q + 1'b1;
    end
  end

  assign round_cnt   = round_cnt_q;
  assign overrun_cnt = overrun_cnt_q;
`endif

  assign eval_req        = req_q;
  assign eval_id         = ptr_q;
  assign eval_ra_en      = ra_mode;
  assign tcas_traffic    = traffic_q;
  assign tcas_resolution = res_q;
  assign threat_id       = tid_q;
  assign busy            = busy_q;
  assign eval_err        = err_q;

endmodule

// File: tb/tb_tcas_track_scheduler.sv
// Bench for tcas_track_scheduler: table-driven rounds plus aging, abort and overrun sequences.
module tb_tcas_track_scheduler;
  import tcas_pkg::*;

  localparam int N_TRK = 4;
  localparam int IDW   = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [1:0]     om = 2'b00;
  logic           upd_valid = 1'b0;
  logic [IDW-1:0] upd_id = '0;
  logic           scan_tick = 1'b0;
  logic           eval_req;
  logic [IDW-1:0] eval_id;
  logic           eval_ra_en;
  logic           eval_ack = 1'b0;
  logic           eval_ta = 1'b0;
  logic           eval_ra = 1'b0;
  logic [2:0]     eval_man = 3'b000;
  logic [2:0]     tcas_traffic, tcas_resolution;
  logic [IDW-1:0] threat_id;
  logic           busy, eval_err;
`ifdef TCAS_STATS_EN
  logic [15:0]    round_cnt, overrun_cnt;
`endif

  always #5 clk = ~clk;

  tcas_track_scheduler dut (
    .clk            (clk),
    .rst            (rst),
    .om             (om),
    .upd_valid      (upd_valid),
    .upd_id         (upd_id),
    .scan_tick      (scan_tick),
    .eval_req       (eval_req),
    .eval_id        (eval_id),
    .eval_ra_en     (eval_ra_en),
    .eval_ack       (eval_ack),
    .eval_ta        (eval_ta),
    .eval_ra        (eval_ra),
    .eval_man       (eval_man),
    .tcas_traffic   (tcas_traffic),
    .tcas_resolution(tcas_resolution),
    .threat_id      (threat_id),
    .busy           (busy),
    .eval_err       (eval_err)
`ifdef TCAS_STATS_EN
    ,
    .round_cnt      (round_cnt),
    .overrun_cnt    (overrun_cnt)
`endif
  );

  typedef struct {
    logic [1:0]  om;
    logic [3:0]  upd;
    logic [3:0]  ta;
    logic [3:0]  ra;
    logic [11:0] man;
    logic        noack;
    int          delay;
    logic        start;
    logic [3:0]  mask;
    logic [2:0]  traffic;
    logic [2:0]  res;
    logic [1:0]  tid;
    logic        err;
    int          len;
  } vec_t;

  vec_t vecs [8];

  int n_chk  = 0;
  int n_fail = 0;

  logic [N_TRK-1:0] rsp_ta, rsp_ra;
  logic [2:0]       rsp_man [N_TRK];
  logic             rsp_noack;
  int               rsp_delay;
  int               last_len;
  int               exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("reset_state", 32'({tcas_traffic, tcas_resolution, threat_id, busy, eval_req, eval_err}), 32'd0);
  endtask

  task automatic update(input int id);
    upd_valid = 1'b1;
    upd_id    = IDW'(id);
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic check_pub(input string name, input logic [2:0] tr, input logic [2:0] rs,
                           input logic [1:0] tid, input logic err);
    check({name, "_traffic"}, 32'(tcas_traffic), 32'(tr));
    check({name, "_resolution"}, 32'(tcas_resolution), 32'(rs));
    check({name, "_threat_id"}, 32'(threat_id), 32'(tid));
    check({name, "_eval_err"}, 32'(eval_err), 32'(err));
  endtask

  // Datapath responder and scoreboard for one scheduling round.
  task automatic run_round(input logic [N_TRK-1:0] exp_mask, input int upd_age_id,
                           input bit mid_tick, input bit exp_start);
    int  cyc    = 0;
    int  cnt    = 0;
    int  limit  = exp_start ? 400 : 20;
    bit  seen   = 0;
    bit  in_req = 0;
    int  e;
    for (int i = 0; i < N_TRK; i++) if (exp_mask[i]) exp_q.push_back(i);
    scan_tick = 1'b1;
    tick();
    scan_tick = 1'b0;
    if (upd_age_id >= 0) begin
      upd_valid = 1'b1;
      upd_id    = IDW'(upd_age_id);
    end
    while (cyc < limit) begin
      if (busy) seen = 1;
      if (seen && !busy) break;
      if (eval_req) begin
        if (!in_req) begin
          in_req = 1;
          cnt    = 0;
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_issue: got slot %0d expected no request", eval_id);
          end else begin
            e = exp_q.pop_front();
            check("issue_id", 32'(eval_id), 32'(e));
            check("eval_ra_en", 32'(eval_ra_en), 32'(om == OM_TARA));
          end
        end
        cnt++;
        if (mid_tick && cnt == 1) scan_tick = 1'b1;
        if (!rsp_noack && cnt == rsp_delay) begin
          eval_ack = 1'b1;
          eval_ta  = rsp_ta[eval_id];
          eval_ra  = rsp_ra[eval_id];
          eval_man = rsp_man[eval_id];
        end
      end else begin
        if (in_req) last_len = cnt;
        in_req = 0;
      end
      tick();
      eval_ack  = 1'b0;
      eval_ta   = 1'b0;
      eval_ra   = 1'b0;
      scan_tick = 1'b0;
      upd_valid = 1'b0;
      cyc++;
    end
    check("round_done", 32'(seen && !busy), 32'(exp_start));
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic set_rsp(input logic [3:0] ta, input logic [3:0] ra, input logic [11:0] man,
                         input logic noack, input int delay);
    rsp_ta    = ta;
    rsp_ra    = ra;
    rsp_noack = noack;
    rsp_delay = delay;
    for (int i = 0; i < N_TRK; i++) rsp_man[i] = man[3*i +: 3];
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit busy_seen;
    //          om     upd      ta       ra       man              nack dly st  mask     trf     res     tid    err len
    vecs[0] = '{2'b10, 4'b0101, 4'b0101, 4'b0100, 12'b000_011_000_000, 0, 3, 1, 4'b0101, 3'd2, 3'd3, 2'd2, 0, 0};
    vecs[1] = '{2'b01, 4'b0101, 4'b0101, 4'b0100, 12'b000_011_000_000, 0, 3, 1, 4'b0101, 3'd2, 3'd1, 2'd0, 0, 0};
    vecs[2] = '{2'b10, 4'b0010, 4'b0000, 4'b0000, 12'b000_000_000_000, 1, 3, 1, 4'b0010, 3'd1, 3'd1, 2'd0, 1, 63};
    vecs[3] = '{2'b10, 4'b1010, 4'b1010, 4'b1010, 12'b011_000_010_000, 0, 1, 1, 4'b1010, 3'd2, 3'd2, 2'd1, 0, 0};
    vecs[4] = '{2'b10, 4'b1111, 4'b0000, 4'b0000, 12'b000_000_000_000, 0, 2, 1, 4'b1111, 3'd1, 3'd1, 2'd0, 0, 0};
    vecs[5] = '{2'b01, 4'b1000, 4'b0000, 4'b1000, 12'b011_000_000_000, 0, 2, 1, 4'b1000, 3'd1, 3'd1, 2'd0, 0, 0};
    vecs[6] = '{2'b11, 4'b0001, 4'b0001, 4'b0000, 12'b000_000_000_000, 0, 1, 0, 4'b0000, 3'd0, 3'd0, 2'd0, 0, 0};
    vecs[7] = '{2'b10, 4'b0110, 4'b0100, 4'b0000, 12'b000_000_000_000, 0, 4, 1, 4'b0110, 3'd2, 3'd1, 2'd2, 0, 0};

    for (int v = 0; v < 8; v++) begin
      do_reset();
      om = vecs[v].om;
      for (int s = 0; s < N_TRK; s++) if (vecs[v].upd[s]) update(s);
      set_rsp(vecs[v].ta, vecs[v].ra, vecs[v].man, vecs[v].noack, vecs[v].delay);
      last_len = 0;
      run_round(vecs[v].mask, -1, 0, vecs[v].start);
      check_pub("vec", vecs[v].traffic, vecs[v].res, vecs[v].tid, vecs[v].err);
      if (vecs[v].len != 0) check("timeout_len", 32'(last_len), 32'(vecs[v].len));
    end

    // Aging: a slot refreshed once survives 14 scans and is dropped on the 15th.
    do_reset();
    om = OM_TARA;
    set_rsp(4'b0000, 4'b0000, 12'd0, 0, 1);
    update(3);
    for (int s = 1; s <= 15; s++) run_round((s < 15) ? 4'b1000 : 4'b0000, -1, 0, 1);
    check_pub("aging", TRAFFIC_NONE, RA_NONE, 2'd0, 1'b0);

    // Refresh landing in the AGE cycle of the 15th scan keeps the slot alive.
    do_reset();
    om = OM_TARA;
    update(3);
    for (int s = 1; s <= 14; s++) run_round(4'b1000, -1, 0, 1);
    run_round(4'b1000, 3, 0, 1);
    run_round(4'b1000, -1, 0, 1);

    // Abort: sticky error, then mode drop during an active request.
    do_reset();
    om = OM_TARA;
    update(1);
    set_rsp(4'b0000, 4'b0000, 12'd0, 1, 1);
    run_round(4'b0010, -1, 0, 1);
    check_pub("abort_pre_timeout", TRAFFIC_NONE, RA_NONE, 2'd0, 1'b1);
    set_rsp(4'b0010, 4'b0010, 12'b000_000_010_000, 0, 1);
    run_round(4'b0010, -1, 0, 1);
    check_pub("abort_pre_ra", TRAFFIC_ADVISORY, RA_DESCEND, 2'd1, 1'b1);
    scan_tick = 1'b1;
    tick();
    scan_tick = 1'b0;
    for (int i = 0; i < 20 && !eval_req; i++) tick();
    check("abort_req_seen", 32'(eval_req), 32'd1);
    om = OM_RESET;
    tick();
    check("abort_eval_req", 32'(eval_req), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check_pub("abort", TRAFFIC_RESET, RA_RESET, 2'd0, 1'b0);
    om = OM_TARA;
    run_round(4'b0010, -1, 0, 1);
    check_pub("abort_resume", TRAFFIC_ADVISORY, RA_DESCEND, 2'd1, 1'b0);

    // Overrun: scan_tick during ISSUE is dropped; exactly one round runs.
    do_reset();
    om = OM_TARA;
    update(0);
    set_rsp(4'b0001, 4'b0000, 12'd0, 0, 3);
    run_round(4'b0001, -1, 1, 1);
    busy_seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy) busy_seen = 1;
      tick();
    end
    check("overrun_no_second_round", 32'(busy_seen), 32'd0);
    check_pub("overrun", TRAFFIC_ADVISORY, RA_NONE, 2'd0, 1'b0);
`ifdef TCAS_STATS_EN
    check("round_cnt", 32'(round_cnt), 32'd1);
    check("overrun_cnt", 32'(overrun_cnt), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
